pipe_chain: RTL and testbench
=============================

PIPE_CHAIN -- requirements
Module: pipe_chain

Interface
REQ-001 SHALL provide parameter STAGES, default 4, number of pipeline register stages; legal range 2..16.
REQ-002 SHALL provide parameter WIDTH, default 32, payload width per stage in bits.
REQ-003 SHALL define IDXW = clog2(STAGES) and OCCW = clog2(STAGES+1) as derived local widths.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  payload offered to stage 0.
REQ-007 SHALL have port in_data  input  WIDTH  payload for stage 0.
REQ-008 SHALL have port in_ready  output  1  stage 0 accepts this cycle.
REQ-009 SHALL have port stall_en  input  1  stall request active.
REQ-010 SHALL have port stall_idx  input  IDXW  youngest-to-this stage index to hold (0 = stage 0).
REQ-011 SHALL have port flush  input  1  flush request active.
REQ-012 SHALL have port flush_idx  input  IDXW  stages 0..flush_idx are invalidated.
REQ-013 SHALL have port stage_valid  output  STAGES  per-stage valid bits, bit i = stage i.
REQ-014 SHALL have port out_valid  output  1  valid bit of stage STAGES-1.
REQ-015 SHALL have port out_data  output  WIDTH  payload of stage STAGES-1.
REQ-016 SHALL have port occupancy  output  OCCW  count of set stage_valid bits.
REQ-017 SHALL have ports stall_cycles and bubble_cycles  output  16 each  statistics counters (see Configuration).

Function
REQ-018 SHALL advance each stage i>0 from stage i-1 every rising edge when neither stall nor flush affects stage i; stage 0 loads in_valid/in_data.
REQ-019 SHALL deliver a payload accepted at edge k to out_valid/out_data after edge k+STAGES-1 when no stall/flush occurs (STAGES-cycle latency, registered output).
REQ-020 SHALL, with stall_en=1 and s=stall_idx, hold valid and data of stages 0..s unchanged.
REQ-021 SHALL, with stall_en=1 and s<STAGES-1, load stage s+1 with valid=0 (bubble), data unchanged; stages >s+1 advance normally.
REQ-022 SHALL, with stall_en=1 and s=STAGES-1, hold the entire chain including out_valid/out_data.
REQ-023 SHALL, with flush=1 and f=flush_idx, clear valid of stages 0..f at the edge, data unchanged; stages >f follow REQ-018/020/021.
REQ-024 SHALL give flush priority over stall for stages 0..f; stages f+1..s hold; bubble at s+1 applies only if s+1>f.
REQ-025 SHALL treat stall_idx or flush_idx values >= STAGES as STAGES-1.
REQ-026 SHALL drive in_ready = ~stall_en & ~flush combinationally; in_valid with in_ready=0 is not captured.
REQ-027 SHALL update payload registers only when the stage loads a valid entry from its predecessor (bubbles keep stale data).
REQ-028 SHALL drive occupancy combinationally from stage_valid; range 0..STAGES.

Reset
REQ-029 SHALL, on reset=1, asynchronously clear all stage_valid bits, out_valid, occupancy, stall_cycles, bubble_cycles, and all payload registers to 0.
REQ-030 SHALL, on reset asserted mid-operation, discard all in-flight payloads with no partial output; first capture follows the first rising edge after deassertion.

Configuration
REQ-031 SHALL, with macro PIPE_CHAIN_STATS_EN defined, increment stall_cycles each edge where stall_en=1 and bubble_cycles each edge where out_valid=0, both saturating at 16'hFFFF.
REQ-032 SHALL, without PIPE_CHAIN_STATS_EN, tie stall_cycles and bubble_cycles to 0 with no counter logic; ports remain present.

Verification
REQ-033 STAGES=4: in_valid=1, in_data=0xA5 for one cycle at edge 0 -> out_valid=1, out_data=0xA5 after edge 3, occupancy 1 for 4 cycles.
REQ-034 Full chain 0x1..0x4, stall_en=1, stall_idx=1 for one edge -> stage 2 valid=0, stage 3=0x2, stages 0..1 hold 0x4/0x3, in_ready=0.
REQ-035 Full chain, flush=1, flush_idx=2, stall_en=1, stall_idx=3 -> stage_valid=4'b1000 with stage 3 holding its value, no bubble.
REQ-036 stall_idx=7 with STAGES=4 -> identical to stall_idx=3: whole chain holds, out_data unchanged.
REQ-037 Reset asserted between edges with occupancy 3 -> stage_valid=0, out_valid=0 immediately, before next edge.
REQ-038 PIPE_CHAIN_STATS_EN defined, stall_en=1 for 70000 cycles -> stall_cycles=0xFFFF, no wrap; undefined -> stays 0.

Source files
------------

// File: rtl/pipe_chain.sv
// Stallable, flushable linear pipeline of STAGES payload registers with per-stage valid bits.
// Optional statistics counters are built when PIPE_CHAIN_STATS_EN is defined.
module pipe_chain #(
    parameter int STAGES = 4,
    parameter int WIDTH  = 32,
    localparam int IDXW  = $clog2(STAGES),
    localparam int OCCW  = $clog2(STAGES + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    input  logic              stall_en,
    input  logic [IDXW-1:0]   stall_idx,
    input  logic              flush,
    input  logic [IDXW-1:0]   flush_idx,
    output logic [STAGES-1:0] stage_valid,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [OCCW-1:0]   occupancy,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       bubble_cycles
);

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q   [STAGES];
    logic [WIDTH-1:0]  src_data [STAGES];
    logic [STAGES-1:0] src_valid;
    logic [STAGES-1:0] clr;
    logic [STAGES-1:0] hold;
    logic [IDXW-1:0]   s_idx;
    logic [IDXW-1:0]   f_idx;

    // Out-of-range indices only exist when STAGES is not a power of two.
    generate
        if ((1 << IDXW) > STAGES) begin : g_clamp
            assign s_idx = (stall_idx > IDXW'(STAGES - 1)) ? IDXW'(STAGES - 1) : stall_idx;
            assign f_idx = (flush_idx > IDXW'(STAGES - 1)) ? IDXW'(STAGES - 1) : flush_idx;
        end else begin : g_direct
            assign s_idx = stall_idx;
            assign f_idx = flush_idx;
        end
    endgenerate

    assign in_ready  = ~stall_en & ~flush;
    assign src_valid = {valid_q[STAGES-2:0], in_valid};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        clr  = '0;
        hold = '0;
        src_data[0] = in_data;
        for (int i = 1; i < STAGES; i++) src_data[i] = data_q[i-1];
        for (int i = 0; i < STAGES; i++) begin
            // Flush wins over stall; the stage just past the held region takes a bubble.
            clr[i]  = (flush && i <= int'(f_idx)) || (stall_en && i == int'(s_idx) + 1);
            hold[i] = stall_en && i <= int'(s_idx);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all stages shift off the same old values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            // NOTE: payload registers are reset too, so no stale data is ever visible after reset.
            for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (clr[i]) begin
                    valid_q[i] <= 1'b0;
                end else if (!hold[i]) begin
                    valid_q[i] <= src_valid[i];
                    if (src_valid[i]) data_q[i] <= src_data[i];
                end
            end
        end
    end

    assign stage_valid = valid_q;
    assign out_valid   = valid_q[STAGES-1];
    assign out_data    = data_q[STAGES-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) occupancy = occupancy + OCCW'(valid_q[i]);
    end

`ifdef PIPE_CHAIN_STATS_EN
    logic [15:0] stall_q;
    logic [15:0] bubble_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (stall_en && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
            if (!valid_q[STAGES-1] && bubble_q != 16'hFFFF) bubble_q <= bubble_q + 16'd1;
        end
    end

    assign stall_cycles  = stall_q;
    assign bubble_cycles = bubble_q;
`else
    assign stall_cycles  = '0;
    assign bubble_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain (STAGES=4, WIDTH=32) with a scoreboard queue for delivered payloads.
module tb_pipe_chain;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        stall_en;
    logic [1:0]  stall_idx;
    logic        flush;
    logic [1:0]  flush_idx;
    logic [3:0]  stage_valid;
    logic        out_valid;
    logic [31:0] out_data;
    logic [2:0]  occupancy;
    logic [15:0] stall_cycles;
    logic [15:0] bubble_cycles;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    pipe_chain #(.STAGES(4), .WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .stall_en(stall_en), .stall_idx(stall_idx),
        .flush(flush), .flush_idx(flush_idx),
        .stage_valid(stage_valid), .out_valid(out_valid), .out_data(out_data),
        .occupancy(occupancy), .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
        logic [31:0] v [4];
        v = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic sb_sample();
        logic [31:0] exp;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_extra", 32'(out_valid), 32'h0);
            end else begin
                exp = exp_q.pop_front();
                check("sb_data", out_data, exp);
            end
        end
    endtask

    task automatic drain(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            tick();
            sb_sample();
        end
        check("sb_empty", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        logic [31:0] v;
        reset = 1'b1; in_valid = 1'b0; in_data = '0;
        stall_en = 1'b0; stall_idx = '0; flush = 1'b0; flush_idx = '0;
        #1;
        check("rst_stage_valid", 32'(stage_valid), 32'h0);
        check("rst_out_valid",   32'(out_valid),   32'h0);
        check("rst_out_data",    out_data,         32'h0);
        check("rst_occupancy",   32'(occupancy),   32'h0);
        check("rst_stall_cyc",   32'(stall_cycles), 32'h0);
        check("rst_bubble_cyc",  32'(bubble_cycles), 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'h1);

        // Single payload: 4-cycle latency, occupancy 1 throughout.
        in_valid = 1'b1; in_data = 32'hA5;
        tick();
        in_valid = 1'b0;
        check("lat_out_valid_e0", 32'(out_valid), 32'h0);
        check("lat_occ_e0", 32'(occupancy), 32'h1);
        tick();
        check("lat_occ_e1", 32'(occupancy), 32'h1);
        tick();
        check("lat_out_valid_e2", 32'(out_valid), 32'h0);
        check("lat_occ_e2", 32'(occupancy), 32'h1);
        tick();
        check("lat_out_valid_e3", 32'(out_valid), 32'h1);
        check("lat_out_data_e3", out_data, 32'hA5);
        check("lat_occ_e3", 32'(occupancy), 32'h1);
        tick();
        check("lat_out_valid_e4", 32'(out_valid), 32'h0);
        check("lat_occ_e4", 32'(occupancy), 32'h0);

        // Back-to-back stream through the scoreboard.
        for (int i = 0; i < 8; i++) begin
            v = $urandom;
            in_valid = 1'b1; in_data = v;
            exp_q.push_back(v);
            tick();
            sb_sample();
        end
        in_valid = 1'b0;
        drain(8);

        // Stall at stage 1: stages 0..1 hold, stage 2 bubbles, stage 3 advances.
        fill(32'h1, 32'h2, 32'h3, 32'h4);
        stall_en = 1'b1; stall_idx = 2'd1; in_valid = 1'b1; in_data = 32'h99;
        #1;
        check("stall1_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("stall1_stage_valid", 32'(stage_valid), 32'hB);
        check("stall1_out_data", out_data, 32'h2);
        stall_en = 1'b0; in_valid = 1'b0;
        exp_q.push_back(32'h3);
        exp_q.push_back(32'h4);
        drain(8);

        // Flush of stages 0..1 alone.
        fill(32'h1, 32'h2, 32'h3, 32'h4);
        flush = 1'b1; flush_idx = 2'd1;
        #1;
        check("flush1_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("flush1_stage_valid", 32'(stage_valid), 32'hC);
        check("flush1_out_data", out_data, 32'h2);
        flush = 1'b0;
        exp_q.push_back(32'h3);
        drain(8);

        // Flush 0..2 beats stall 0..3; stage 3 holds, no bubble.
        fill(32'h1, 32'h2, 32'h3, 32'h4);
        flush = 1'b1; flush_idx = 2'd2; stall_en = 1'b1; stall_idx = 2'd3;
        tick();
        check("fs_stage_valid", 32'(stage_valid), 32'h8);
        check("fs_out_data", out_data, 32'h1);
        check("fs_occupancy", 32'(occupancy), 32'h4 - 32'h3);
        flush = 1'b0; stall_en = 1'b0;
        drain(6);

        // All-ones stall index (7 truncated to 2 bits) freezes the whole chain.
        fill(32'h1, 32'h2, 32'h3, 32'h4);
        stall_en = 1'b1; stall_idx = '1; in_valid = 1'b1; in_data = 32'h55;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_stage_valid", 32'(stage_valid), 32'hF);
            check("hold_out_data", out_data, 32'h1);
        end
        stall_en = 1'b0; in_valid = 1'b0;
        exp_q.push_back(32'h2);
        exp_q.push_back(32'h3);
        exp_q.push_back(32'h4);
        drain(8);

        // Asynchronous reset between edges with three entries in flight.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'h7 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_occupancy", 32'(occupancy), 32'h3);
        #3;
        reset = 1'b1;
        #1;
        check("arst_stage_valid", 32'(stage_valid), 32'h0);
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_occupancy", 32'(occupancy), 32'h0);
        tick();
        reset = 1'b0;
        drain(6);

`ifdef PIPE_CHAIN_STATS_EN
        check("stats_stall_zero", 32'(stall_cycles), 32'h0);
        stall_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("stats_stall_5", 32'(stall_cycles), 32'h5);
        for (int i = 0; i < 70000; i++) tick();
        check("stats_stall_sat", 32'(stall_cycles), 32'hFFFF);
        check("stats_bubble_sat", 32'(bubble_cycles), 32'hFFFF);
        stall_en = 1'b0;
        tick();
        check("stats_stall_nowrap", 32'(stall_cycles), 32'hFFFF);
`else
        stall_en = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("stats_off_stall", 32'(stall_cycles), 32'h0);
        check("stats_off_bubble", 32'(bubble_cycles), 32'h0);
        stall_en = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
